// File: rtl/rv_iommu_ds_xbar.sv
// N-client AXI master multiplexer for the IOMMU data-structure bus: round-robin AR/AW
// arbitration with grant lock, W ordering FIFO, ID-based R/B routing and outstanding limits.

package rv_iommu_ds_xbar_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;
endpackage

module rv_iommu_ds_xbar #(
  parameter int unsigned        N_PORTS      = 7,
  parameter logic [N_PORTS-1:0] RD_MASK      = 7'b0011111,
  parameter logic [N_PORTS-1:0] WR_MASK      = 7'b1111000,
  parameter int unsigned        ID_WIDTH     = 4,
  parameter int unsigned        W_FIFO_DEPTH = 4,
  parameter int unsigned        MAX_RD_OUTST = 8,
  parameter int unsigned        MAX_WR_OUTST = 8,
  parameter type aw_chan_t = rv_iommu_ds_xbar_pkg::aw_chan_t,
  parameter type w_chan_t  = rv_iommu_ds_xbar_pkg::w_chan_t,
  parameter type b_chan_t  = rv_iommu_ds_xbar_pkg::b_chan_t,
  parameter type ar_chan_t = rv_iommu_ds_xbar_pkg::ar_chan_t,
  parameter type r_chan_t  = rv_iommu_ds_xbar_pkg::r_chan_t,
  parameter type axi_req_t = rv_iommu_ds_xbar_pkg::axi_req_t,
  parameter type axi_rsp_t = rv_iommu_ds_xbar_pkg::axi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  axi_req_t cl_req_i  [N_PORTS],
  output axi_rsp_t cl_resp_o [N_PORTS],
  output axi_req_t ds_req_o,
  input  axi_rsp_t ds_resp_i,
  output logic     idle_o,
  output logic     err_id_o
);

  localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int PTR_W  = (W_FIFO_DEPTH > 1) ? $clog2(W_FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(W_FIFO_DEPTH + 1);
  localparam int RCNT_W = $clog2(MAX_RD_OUTST + 1);
  localparam int WCNT_W = $clog2(MAX_WR_OUTST + 1);

  typedef logic [IDX_W-1:0] idx_t;

  // Returns {found, index}: first candidate at or above ptr, wrapping to 0.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_PORTS-1:0] cand, input idx_t ptr);
    logic [IDX_W:0] res;
    logic           found;
    int             j;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      j = int'(ptr) + k;
      if (j >= int'(N_PORTS)) j = j - int'(N_PORTS);
      if (!found && cand[j]) begin
        found = 1'b1;
        res   = {1'b1, IDX_W'(j)};
      end
    end
    return res;
  endfunction

  function automatic idx_t rr_next(input idx_t g);
    return (int'(g) == int'(N_PORTS) - 1) ? '0 : g + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == int'(W_FIFO_DEPTH) - 1) ? '0 : p + 1'b1;
  endfunction

  logic                ar_lock_reg, aw_lock_reg;
  idx_t                ar_lock_idx_reg, aw_lock_idx_reg;
  idx_t                rr_ar_reg, rr_aw_reg;
  idx_t                fifo_mem [W_FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [FCNT_W-1:0]   fifo_cnt_reg;
  logic [RCNT_W-1:0]   rd_cnt_reg;
  logic [WCNT_W-1:0]   wr_cnt_reg;
  logic                err_reg;

  logic [N_PORTS-1:0]  ar_cand, aw_cand, r_hit, b_hit, r_rdy_vec, b_rdy_vec;
  logic [IDX_W:0]      ar_pick, aw_pick;
  idx_t                ar_idx, aw_idx, w_head;
  logic                ar_valid, aw_valid, w_valid, ar_hs, aw_hs, w_pop;
  logic                fifo_full, fifo_empty;
  logic [ID_WIDTH-1:0] r_id, b_id;
  logic                r_ok, b_ok, r_ready, b_ready, r_done, b_done, err_next;
  ar_chan_t            ar_sel;
  aw_chan_t            aw_sel;
  w_chan_t             w_sel;
  r_chan_t             r_bcast;
  b_chan_t             b_bcast;

  assign r_id    = ds_resp_i.r.id;
  assign b_id    = ds_resp_i.b.id;
  assign r_bcast = ds_resp_i.r;
  assign b_bcast = ds_resp_i.b;

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_client
      axi_rsp_t rsp;
      assign ar_cand[gi]   = RD_MASK[gi] && cl_req_i[gi].ar_valid;
      assign aw_cand[gi]   = WR_MASK[gi] && cl_req_i[gi].aw_valid;
      assign r_hit[gi]     = RD_MASK[gi] && (r_id == ID_WIDTH'(gi));
      assign b_hit[gi]     = WR_MASK[gi] && (b_id == ID_WIDTH'(gi));
      assign r_rdy_vec[gi] = cl_req_i[gi].r_ready;
      assign b_rdy_vec[gi] = cl_req_i[gi].b_ready;

      always_comb begin
        rsp = '0;
        if (RD_MASK[gi]) begin
          rsp.ar_ready = ar_valid && (ar_idx == idx_t'(gi)) && ds_resp_i.ar_ready;
          rsp.r        = r_bcast;
          rsp.r_valid  = ds_resp_i.r_valid && r_hit[gi];
        end else begin
          rsp.r.resp = 2'b10;
        end
        if (WR_MASK[gi]) begin
          rsp.aw_ready = aw_valid && (aw_idx == idx_t'(gi)) && ds_resp_i.aw_ready;
          rsp.w_ready  = !rst_i && !fifo_empty && (w_head == idx_t'(gi)) && ds_resp_i.w_ready;
          rsp.b        = b_bcast;
          rsp.b_valid  = ds_resp_i.b_valid && b_hit[gi];
        end else begin
          rsp.b.resp = 2'b10;
        end
      end
      assign cl_resp_o[gi] = rsp;
    end
  endgenerate

  // A locked grant stays presented until its ready, regardless of the limits.
  assign ar_pick  = rr_pick(ar_cand, rr_ar_reg);
  assign ar_idx   = ar_lock_reg ? ar_lock_idx_reg : ar_pick[IDX_W-1:0];
  assign ar_valid = !rst_i && (ar_lock_reg ||
                    (ar_pick[IDX_W] && (rd_cnt_reg < RCNT_W'(MAX_RD_OUTST))));
  assign ar_hs    = ar_valid && ds_resp_i.ar_ready;

  assign fifo_full  = (fifo_cnt_reg == FCNT_W'(W_FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_reg == '0);

  assign aw_pick  = rr_pick(aw_cand, rr_aw_reg);
  assign aw_idx   = aw_lock_reg ? aw_lock_idx_reg : aw_pick[IDX_W-1:0];
  assign aw_valid = !rst_i && (aw_lock_reg ||
                    (aw_pick[IDX_W] && !fifo_full && (wr_cnt_reg < WCNT_W'(MAX_WR_OUTST))));
  assign aw_hs    = aw_valid && ds_resp_i.aw_ready;

  assign w_head  = fifo_mem[rd_ptr_reg];
  assign w_valid = !rst_i && !fifo_empty && cl_req_i[w_head].w_valid;
  assign w_pop   = w_valid && ds_resp_i.w_ready && cl_req_i[w_head].w.last;

  // Unroutable beats are drained by forcing ready.
  assign r_ok     = |r_hit;
  assign b_ok     = |b_hit;
  assign r_ready  = r_ok ? |(r_hit & r_rdy_vec) : 1'b1;
  assign b_ready  = b_ok ? |(b_hit & b_rdy_vec) : 1'b1;
  assign r_done   = ds_resp_i.r_valid && r_ready && ds_resp_i.r.last;
  assign b_done   = ds_resp_i.b_valid && b_ready;
  assign err_next = (ds_resp_i.r_valid && !r_ok) || (ds_resp_i.b_valid && !b_ok);

  always_comb begin
    ar_sel    = cl_req_i[ar_idx].ar;
    ar_sel.id = ID_WIDTH'(ar_idx);
    aw_sel    = cl_req_i[aw_idx].aw;
    aw_sel.id = ID_WIDTH'(aw_idx);
    w_sel     = cl_req_i[w_head].w;
    ds_req_o          = '0;
    ds_req_o.ar       = ar_sel;
    ds_req_o.ar_valid = ar_valid;
    ds_req_o.aw       = aw_sel;
    ds_req_o.aw_valid = aw_valid;
    ds_req_o.w        = w_sel;
    ds_req_o.w_valid  = w_valid;
    ds_req_o.r_ready  = r_ready;
    ds_req_o.b_ready  = b_ready;
  end

  always_ff @(posedge clk_i) begin
    if (aw_hs) fifo_mem[wr_ptr_reg] <= aw_idx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ar_lock_reg     <= 1'b0;
      aw_lock_reg     <= 1'b0;
      ar_lock_idx_reg <= '0;
      aw_lock_idx_reg <= '0;
      rr_ar_reg       <= '0;
      rr_aw_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fifo_cnt_reg    <= '0;
      rd_cnt_reg      <= '0;
      wr_cnt_reg      <= '0;
      err_reg         <= 1'b0;
    end else begin
      ar_lock_reg     <= ar_valid && !ds_resp_i.ar_ready;
      aw_lock_reg     <= aw_valid && !ds_resp_i.aw_ready;
      ar_lock_idx_reg <= ar_idx;
      aw_lock_idx_reg <= aw_idx;
      if (ar_hs) rr_ar_reg <= rr_next(ar_idx);
      if (aw_hs) rr_aw_reg <= rr_next(aw_idx);
      if (aw_hs) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (w_pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({aw_hs, w_pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
      case ({ar_hs, r_done})
        2'b10:   rd_cnt_reg <= rd_cnt_reg + 1'b1;
        2'b01:   rd_cnt_reg <= (rd_cnt_reg != '0) ? rd_cnt_reg - 1'b1 : '0;
        default: rd_cnt_reg <= rd_cnt_reg;
      endcase
      case ({aw_hs, b_done})
        2'b10:   wr_cnt_reg <= wr_cnt_reg + 1'b1;
        2'b01:   wr_cnt_reg <= (wr_cnt_reg != '0) ? wr_cnt_reg - 1'b1 : '0;
        default: wr_cnt_reg <= wr_cnt_reg;
      endcase
      err_reg <= err_next;
    end
  end

  assign idle_o   = (rd_cnt_reg == '0) && (wr_cnt_reg == '0) && fifo_empty;
  assign err_id_o = err_reg;

endmodule

// File: doc/rv_iommu_ds_xbar.md
# rv_iommu_ds_xbar

Parametrised N-client AXI master multiplexer for the IOMMU data-structure bus. It merges the AR/AW/W channels of the IOMMU's internal memory clients (PTW, CDW, MSI PTW, MRIF handler, CQ, FQ, MSI IG, …) onto one downstream AXI master port. It overwrites outgoing IDs with the client index and routes R/B responses back by that ID. Compared with the fixed-port DS interface, it adds:
- configurable client count and read/write capability per client;
- fair round-robin arbitration with grant lock;
- a back-pressured W-ordering FIFO of configurable depth;
- outstanding-transaction limits, an idle indication and error flagging of unroutable responses.

## Interface
- `N_PORTS`, 7: number of client ports; client `i` uses AXI ID `i`.
- `RD_MASK`, `7'b0011111`: bit `i` = 1 means client `i` may issue reads.
- `WR_MASK`, `7'b1111000`: bit `i` = 1 means client `i` may issue writes.
- `ID_WIDTH`, 4: downstream AXI ID width. Must satisfy `ID_WIDTH >= $clog2(N_PORTS)`.
- `W_FIFO_DEPTH`, 4: W-ordering FIFO depth, which is also the maximum number of AWs awaiting write data. Must be ≥ 1.
- `MAX_RD_OUTST`, 8: maximum number of ARs without a final R beat.
- `MAX_WR_OUTST`, 8: maximum number of AWs without a B response.
- `aw_chan_t`, `w_chan_t`, `b_chan_t`, `ar_chan_t`, `r_chan_t`, `axi_req_t`, `axi_rsp_t`, `logic`: AXI channel and bundle types.
- `clk_i` input 1: clock. All state updates on its rising edge.
- `rst_i` input 1: **asynchronous, active-high reset**.
- `cl_req_i` input `[N_PORTS]` `axi_req_t`: client requests.
- `cl_resp_o` output `[N_PORTS]` `axi_rsp_t`: client responses.
- `ds_req_o` output `axi_req_t`: downstream request.
- `ds_resp_i` input `axi_rsp_t`: downstream response.
- `idle_o` output 1: high when there are no outstanding reads or writes and the W FIFO is empty.
- `err_id_o` output 1: one-cycle pulse per unroutable R or B beat.

## Operation
**AR arbiter**
- Candidates: clients `i` with `RD_MASK[i]` set and `ar_valid` high.
- Round-robin: search starts at pointer `rr_ar` and picks the lowest index at or above it, wrapping to 0.
- Once `ds_req_o.ar_valid` rises, grant and payload are held until `ds_resp_i.ar_ready` (lock). After the handshake, `rr_ar` = granted index + 1, modulo `N_PORTS`.
- `ds_req_o.ar.id` = granted index, zero-extended to `ID_WIDTH`. All other AR fields pass through unchanged.
- AR is presented only when `rd_cnt < MAX_RD_OUTST`.

**AW arbiter**
- Same scheme as AR, using `WR_MASK` and pointer `rr_aw`.
- AW is presented only when the W FIFO is not full and `wr_cnt < MAX_WR_OUTST`.

**W FIFO**
- Each AW handshake pushes the granted index.
- The FIFO head selects which client's W channel is muxed downstream.
- A W handshake with `last` = 1 pops the head.
- While the FIFO is empty: `ds_req_o.w_valid` = 0 and every `w_ready` = 0. There is no default client.

**Counters**
- `rd_cnt`: +1 on AR handshake, −1 on R handshake with `last` = 1.
- `wr_cnt`: +1 on AW handshake, −1 on B handshake.
- Increment and decrement in the same cycle leave the count unchanged.
- Decrement saturates at 0.
- Width is `$clog2(MAX+1)`.

**R/B routing**
- Index = `ds_resp_i.r.id` (or `.b.id`).
- Valid, ready and payload of the routed client are connected; every other client sees `valid` = 0. Payload is broadcast to all read- or write-enabled clients.
- If the index is ≥ `N_PORTS`, or the relevant mask bit is 0: `ready` is forced to 1 (the beat is drained), `err_id_o` pulses, and the counters still update.

**Disabled directions**
- Clients without read enable: `ar_ready` = 0, `r_valid` = 0, `r` = 0, `r.resp` = SLVERR.
- Clients without write enable: `aw_ready` = 0, `w_ready` = 0, `b_valid` = 0, `b` = 0, `b.resp` = SLVERR.

## Timing
**Reset values**
- All downstream valids 0, all client readys 0.
- `rr_ar` = `rr_aw` = 0, counters 0, FIFO empty.
- `idle_o` = 1, `err_id_o` = 0.
- Reset asserted mid-operation discards all in-flight state immediately. Outstanding downstream responses arriving after reset are routed by ID but do not underflow the counters (saturation).

**Latencies**
- AR/AW: combinational, zero-cycle path from client to downstream.
- W: the first W beat can pass no earlier than the cycle after its AW handshake. There is no FIFO bypass.
- R/B: combinational.
- `err_id_o`: registered, high the cycle after the offending handshake.

**Boundary rules**
- W FIFO full: AW is blocked even if a pop happens in the same cycle.
- W FIFO with one entry: pop on last beat plus a simultaneous push is legal, and the next head is used in the following cycle.
- Counter at MAX with a decrement in the same cycle: the arbiter is still blocked in that cycle and may grant in the next.
- Downstream `ar_valid`/`aw_valid` never drop before their ready (AXI stability).

## Test plan
- **Round-robin AR:** `N_PORTS` = 7, clients 0, 2, 4 hold `ar_valid`, `ar_ready` = 1 → grant order 0, 2, 4, 0, 2; downstream ARIDs 0, 2, 4.
- **Grant lock:** client 1 is granted with `ar_ready` = 0 for 5 cycles while client 0 asserts → AR payload and ID = 1 stable for all 5 cycles; client 0 is granted next.
- **W ordering with full FIFO:** `W_FIFO_DEPTH` = 2, AWs from clients 6, 3, 5 with `w_ready` = 0 → AW 6 and AW 3 accepted, AW 5 stalled; W beats drain 6 then 3, then AW 5 is accepted the cycle after the first pop.
- **Outstanding limit:** `MAX_RD_OUTST` = 2, three ARs, no R → third AR stalls; one R with `last` = 1 → third AR handshakes the next cycle; `idle_o` = 0 throughout.
- **Bad response ID:** R with ID 9 (and, separately, B with ID 1 where `WR_MASK[1]` = 0) → `r_ready`/`b_ready` = 1, no client sees valid, `err_id_o` = 1 for exactly one cycle.
- **Reset mid-burst:** `rst_i` pulsed during a 4-beat W burst → all valids 0 and `idle_o` = 1 immediately; FIFO empty; the next AW starts with `rr_aw` = 0.
